div_unit: RTL and testbench

Multi-cycle 32-bit divider and its sequencing FSM for the EX stage. It serves DIV and DIVU. EX raises `start_i` with both operands and holds the request until `ready_o`, while stalling the pipeline on `busy_o`. The block produces the 64-bit {remainder, quotient} result that EX forwards to HI/LO. It computes one quotient bit per cycle (restoring division), handles signed operands by magnitude conversion and sign correction, short-circuits divide-by-zero, and supports cancellation when EX is flushed.

---
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after 32 iterations, or zero at once for a zero divisor.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        sgn;
  logic        neg1;
  logic        neg2;

  logic        accept;
  logic        last_iter;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  // The partial remainder stays below the divisor, so bit 32 of the difference is a clean borrow flag.
  always_comb begin
    accept    = start_i && !annul_i;
    last_iter = (cnt == 6'd31);
    mag1      = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2      = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    shifted   = {rem, dvd[31]};
    diff      = shifted - {1'b0, dvs};
    q_bit     = ~diff[32];
    rem_step  = q_bit ? diff[31:0] : shifted[31:0];
    quo_final = {dvd[30:0], q_bit};
    rem_final = rem_step;
    if (sgn && (neg1 ^ neg2)) quo_final = ~quo_final + 32'd1;
    if (sgn && neg1)          rem_final = ~rem_final + 32'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
      S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)        state_next = S_IDLE;
        else if (last_iter) state_next = S_END;
      end
      S_END:    if (!start_i) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // The dividend register doubles as the quotient register: dividend bits leave at the top as quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 6'd0;
      rem  <= 32'd0;
      dvd  <= 32'd0;
      dvs  <= 32'd0;
      sgn  <= 1'b0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept && (opdata2_i != 32'd0)) begin
        cnt  <= 6'd0;
        rem  <= 32'd0;
        dvd  <= mag1;
        dvs  <= mag2;
        sgn  <= signed_div_i;
        neg1 <= opdata1_i[31];
        neg2 <= opdata2_i[31];
      end
    end else if (state == S_ON) begin
      cnt <= cnt + 6'd1;
      rem <= rem_step;
      dvd <= {dvd[30:0], q_bit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_next == S_END);
      if (state == S_ON && state_next == S_END) result_o <= {rem_final, quo_final};
      else if (state_next != S_END)             result_o <= 64'd0;
    end
  end

  assign busy_o = (state == S_ON) || (state == S_BYZERO);

endmodule

// File: tb/tb_div_unit.sv
// Randomised self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating division on 64-bit integers: remainder takes the dividend's sign, INT_MIN/-1 wraps.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one request after a falling edge and waits (bounded) for ready; no checking here.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat, output int busy_cnt, output bit tout);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    res      = 64'd0;
    lat      = -1;
    busy_cnt = 0;
    tout     = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (ready_o) begin
        lat  = k - 1;
        res  = result_o;
        tout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready_o, busy_o, result_o} !== 66'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got ready=%b busy=%b result=%h, want all 0", ready_o, busy_o, result_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got ready=%b busy=%b, want 0 0", ready_o, busy_o);
    end
  endtask

  task automatic test_unsigned;
    logic [63:0] res; int lat, bc; bit tout;
    issue(1'b0, 32'd100, 32'd7, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== {32'd2, 32'd14}) begin
      n_fail++;
      $display("[TB] FAIL divu_100_7: got %h (timeout=%0b), want %h", res, tout, {32'd2, 32'd14});
    end
    n_checks++;
    if (lat !== 32 || bc !== 32) begin
      n_fail++;
      $display("[TB] FAIL divu_timing: got latency=%0d busy=%0d, want 32 32", lat, bc);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed;
    logic [63:0] res; int lat, bc; bit tout;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("[TB] FAIL div_m7_2: got %h, want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    start_i = 1'b0;
    @(negedge clk);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== {32'd0, 32'h8000_0000}) begin
      n_fail++;
      $display("[TB] FAIL div_intmin_m1: got %h, want %h", res, {32'd0, 32'h8000_0000});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    logic [63:0] res; int lat, bc; bit tout;
    issue(1'b1, 32'd5, 32'd0, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== 64'd0 || lat !== 1 || bc !== 1) begin
      n_fail++;
      $display("[TB] FAIL div_by_zero: got result=%h latency=%0d busy=%0d, want 0 1 1", res, lat, bc);
    end
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL div_zero_release: got ready=%b result=%h, want 0 0", ready_o, result_o);
    end
  endtask

  task automatic test_annul;
    logic [63:0] res; int lat, bc; bit tout; int seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b0;
    repeat (10) @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o || busy_o) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL annul_on: got %0d cycles with ready/busy after annul, want 0", seen);
    end
    // Annul while in the zero-divisor state.
    opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL annul_byzero: got ready=%b busy=%b, want 0 0", ready_o, busy_o);
    end
    // A request presented together with annul is not accepted.
    opdata2_i = 32'd9; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL annul_idle_reject: got busy=%b, want 0", busy_o);
    end
    start_i = 1'b0; annul_i = 1'b0;
    issue(1'b0, 32'hFFFF_FFFF, 32'h10, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== {32'hF, 32'h0FFF_FFFF} || lat !== 32) begin
      n_fail++;
      $display("[TB] FAIL after_annul: got %h latency=%0d, want %h 32", res, lat, {32'hF, 32'h0FFF_FFFF});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand_hold;
    logic [63:0] exp; logic [63:0] got; bit tout; int bad;
    exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b0;
    repeat (5) @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = $urandom; opdata2_i = 32'd0;
    tout = 1'b1; got = 64'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      opdata1_i = $urandom;
      if (ready_o) begin
        got  = result_o;
        tout = 1'b0;
        break;
      end
    end
    n_checks++;
    if (tout || got !== exp) begin
      n_fail++;
      $display("[TB] FAIL operand_hold: got %h (timeout=%0b), want %h", got, tout, exp);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== exp) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL end_hold: got %0d unstable cycles, want 0", bad);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [63:0] res; int lat, bc; bit tout;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1; annul_i = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ready_o, busy_o, result_o} !== 66'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got ready=%b busy=%b result=%h, want all 0", ready_o, busy_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 32'd12345, 32'd11, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== ref_div(1'b0, 32'd12345, 32'd11) || lat !== 32) begin
      n_fail++;
      $display("[TB] FAIL after_reset: got %h latency=%0d, want %h 32", res, lat, ref_div(1'b0, 32'd12345, 32'd11));
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [63:0] res; int lat, bc; bit tout;
    issue(1'b1, 32'hFFFF_FC18, 32'd33, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== ref_div(1'b1, 32'hFFFF_FC18, 32'd33)) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got %h, want %h", res, ref_div(1'b1, 32'hFFFF_FC18, 32'd33));
    end
    start_i = 1'b0;
    issue(1'b0, 32'd77777, 32'd250, res, lat, bc, tout);
    n_checks++;
    if (tout || res !== ref_div(1'b0, 32'd77777, 32'd250) || lat !== 32) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got %h latency=%0d, want %h 32", res, lat, ref_div(1'b0, 32'd77777, 32'd250));
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [63:0] res, exp; int lat, bc, exp_lat; bit tout; bit s; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 6 == 5) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      exp     = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 1 : 32;
      issue(s, a, b, res, lat, bc, tout);
      n_checks++;
      if (tout || res !== exp || lat != exp_lat || bc != exp_lat) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: s=%0b a=%h b=%h got %h lat=%0d busy=%0d, want %h lat=%0d",
                 i, s, a, b, res, lat, bc, exp, exp_lat);
      end
      start_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        n_fail++;
        $display("[TB] FAIL random_release_%0d: got ready=%b result=%h, want 0 0", i, ready_o, result_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_operand_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
